// File: rtl/tetris_pkg.sv
// Shared playfield types: board geometry defaults,
// engine state encoding, read-owner tags, cell addressing.
package tetris_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CW   = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    COL_RD,
    COL_WR,
    COL_TOP
  } eng_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_ENG,
    TAG_GM
  } tag_e;

  // row*cols+col; the 10-wide board uses shift-add
  function automatic logic [7:0] cell_addr(
    input logic [7:0] row,
    input logic [7:0] col,
    input int         cols
  );
    if (cols == 10) begin
      return 8'({row, 3'b000}
              + {2'b00, row, 1'b0}
              + {3'b000, col});
    end
    return 8'(32'(row) * cols + 32'(col));
  endfunction

endpackage

// File: rtl/playfield_arb.sv
// Playfield RAM arbiter: display > engine > game,
// plus clear / row-collapse engine on the shared port.
module playfield_arb #(
  parameter int COLS = tetris_pkg::COLS,
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int CW   = tetris_pkg::CW
) (
  input  logic          CLK25M,
  input  logic          RST,
  input  logic          disp_req,
  input  logic [7:0]    disp_addr,
  output logic          disp_valid,
  output logic [CW-1:0] disp_data,
  input  logic          gm_req,
  input  logic          gm_we,
  input  logic [7:0]    gm_addr,
  input  logic [CW-1:0] gm_wdata,
  output logic          gm_ack,
  output logic [CW-1:0] gm_rdata,
  input  logic          cmd_clear,
  input  logic          cmd_collapse,
  input  logic [4:0]    cmd_row,
  output logic          eng_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [7:0]    mem_addr,
  output logic [CW-1:0] mem_wdata,
  input  logic [CW-1:0] mem_rdata
);
  import tetris_pkg::*;

  localparam logic [3:0] COL_LAST = 4'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [5:0] ROW_CNT  = 6'(ROWS);

  eng_state_e    state_q, state_d;
  logic [4:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  tag_e          tag_q, tag_d;
  logic          gm_ack_q, gm_ack_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          disp_gnt, eng_gnt, gm_gnt;
  logic          col_last;
  logic [7:0]    eng_addr;
  logic [CW-1:0] wr_data;

  assign eng_busy   = (state_q != IDLE);
  assign disp_valid = (tag_q == TAG_DISP);
  assign disp_data  = disp_valid ? mem_rdata : '0;
  assign gm_ack     = gm_ack_q;
  assign gm_rdata   = (tag_q == TAG_GM) ? mem_rdata : '0;
  assign col_last   = (col_q == COL_LAST);
  // fresh read data if the COL_RD just returned, else the capture
  assign wr_data    = (tag_q == TAG_ENG) ? mem_rdata : rd_q;

  // fixed-priority grant; nothing is granted during reset
  always_comb begin
    disp_gnt = !RST && disp_req;
    eng_gnt  = !RST && !disp_req && eng_busy;
    gm_gnt   = !RST && !disp_req && !eng_busy && gm_req;
  end

  // engine cell address: COL_RD looks one row up
  always_comb begin
    eng_addr = '0;
    case (state_q)
      COL_RD:  eng_addr = cell_addr({3'b000, row_q - 5'd1},
                                    {4'b0000, col_q}, COLS);
      default: eng_addr = cell_addr({3'b000, row_q},
                                    {4'b0000, col_q}, COLS);
    endcase
  end

  // RAM port mux and read-owner tag for next cycle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    gm_ack_d  = gm_gnt;
    rd_d      = (tag_q == TAG_ENG) ? mem_rdata : rd_q;
    unique case (1'b1)
      disp_gnt: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
        tag_d    = TAG_DISP;
      end
      eng_gnt: begin
        mem_en   = 1'b1;
        mem_we   = (state_q != COL_RD);
        mem_addr = eng_addr;
        if (state_q == COL_WR) mem_wdata = wr_data;
        if (state_q == COL_RD) tag_d = TAG_ENG;
      end
      gm_gnt: begin
        mem_en   = 1'b1;
        mem_we   = gm_we;
        mem_addr = gm_addr;
        if (gm_we) mem_wdata = gm_wdata;
        else       tag_d     = TAG_GM;
      end
      default: ;
    endcase
  end

  // engine next state; pointers move only on granted cycles
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          state_d = CLR;
          row_d   = '0;
          col_d   = '0;
        end else if (cmd_collapse
                     && {1'b0, cmd_row} < ROW_CNT) begin
          row_d   = cmd_row;
          col_d   = '0;
          state_d = (cmd_row == 5'd0) ? COL_TOP : COL_RD;
        end
      end
      CLR: begin
        if (eng_gnt) begin
          if (col_last) begin
            col_d = '0;
            if (row_q == ROW_LAST) state_d = IDLE;
            else                   row_d   = row_q + 5'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      COL_RD: begin
        if (eng_gnt) state_d = COL_WR;
      end
      COL_WR: begin
        if (eng_gnt) begin
          state_d = COL_RD;
          if (col_last) begin
            col_d = '0;
            if (row_q == 5'd1) begin
              state_d = COL_TOP;
              row_d   = '0;
            end else begin
              row_d = row_q - 5'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      COL_TOP: begin
        if (eng_gnt) begin
          if (col_last) begin
            state_d = IDLE;
            col_d   = '0;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK25M) begin
    if (RST) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      tag_q    <= TAG_NONE;
      gm_ack_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      tag_q    <= tag_d;
      gm_ack_q <= gm_ack_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_playfield_arb.sv
// Directed bench for playfield_arb with external RAM model,
// golden board image and read-data scoreboards.
module tb_playfield_arb;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          RST;
  logic          disp_req;
  logic [7:0]    disp_addr;
  logic          disp_valid;
  logic [CW-1:0] disp_data;
  logic          gm_req, gm_we;
  logic [7:0]    gm_addr;
  logic [CW-1:0] gm_wdata;
  logic          gm_ack;
  logic [CW-1:0] gm_rdata;
  logic          cmd_clear, cmd_collapse;
  logic [4:0]    cmd_row;
  logic          eng_busy;
  logic          mem_en, mem_we;
  logic [7:0]    mem_addr;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;

  logic [CW-1:0] ram [256] = '{default: 3'd7};
  logic [CW-1:0] golden [256];
  logic [CW-1:0] disp_q [$];
  logic [CW-1:0] gm_q [$];
  logic          prev_req = 1'b0;

  int total = 0;
  int bad   = 0;
  int n;

  playfield_arb dut (
    .CLK25M      (clk),
    .RST         (RST),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .gm_req      (gm_req),
    .gm_we       (gm_we),
    .gm_addr     (gm_addr),
    .gm_wdata    (gm_wdata),
    .gm_ack      (gm_ack),
    .gm_rdata    (gm_rdata),
    .cmd_clear   (cmd_clear),
    .cmd_collapse(cmd_collapse),
    .cmd_row     (cmd_row),
    .eng_busy    (eng_busy),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // display scoreboard and port-ownership check
  always @(negedge clk) begin
    chk("disp_valid", 32'(disp_valid), 32'(prev_req));
    if (disp_valid) begin
      if (disp_q.size() == 0) chk("disp_q_empty", 1, 0);
      else chk("disp_data", 32'(disp_data),
               32'(disp_q.pop_front()));
    end
    if (disp_req) begin
      disp_q.push_back(golden[disp_addr]);
      chk("disp_gnt", 32'({mem_en, mem_we, mem_addr}),
          32'({2'b10, disp_addr}));
    end
    prev_req = disp_req;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gm_txn(input logic we,
                        input logic [7:0] a,
                        input logic [CW-1:0] d);
    int k = 0;
    gm_req = 1'b1; gm_we = we;
    gm_addr = a; gm_wdata = d;
    if (we) golden[a] = d;
    else    gm_q.push_back(golden[a]);
    do begin step(); k++; end
    while (!gm_ack && k < 50);
    chk("gm_lat", k, 1);
    if (!we) chk("gm_rdata", 32'(gm_rdata),
                 32'(gm_q.pop_front()));
    gm_req = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (eng_busy && k < 3000) begin step(); k++; end
    chk("idle_to", 32'(eng_busy), 0);
  endtask

  task automatic collapse_model(input int row);
    for (int r = row; r >= 1; r--)
      for (int c = 0; c < 10; c++)
        golden[r*10+c] = golden[(r-1)*10+c];
    for (int c = 0; c < 10; c++) golden[c] = '0;
  endtask

  task automatic fill_bottom();
    for (int r = 17; r < 20; r++)
      for (int c = 0; c < 10; c++)
        gm_txn(1'b1, 8'(r*10+c), 3'(r-16));
  endtask

  task automatic verify_all();
    for (int a = 0; a < 200; a++) gm_txn(1'b0, 8'(a), '0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) golden[a] = 3'd7;
    RST = 1'b1; disp_req = 1'b0; disp_addr = '0;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0;
    gm_wdata = '0; cmd_clear = 1'b0;
    cmd_collapse = 1'b0; cmd_row = '0;
    repeat (3) step();
    chk("rst_busy", 32'(eng_busy), 0);
    chk("rst_ack", 32'(gm_ack), 0);
    chk("rst_dv", 32'(disp_valid), 0);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_ddata", 32'(disp_data), 0);
    chk("rst_grdata", 32'(gm_rdata), 0);
    RST = 1'b0;
    step();

    // clear: 200 ascending zero writes
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    for (int i = 0; i < 200; i++) begin
      chk("clr_busy", 32'(eng_busy), 1);
      chk("clr_wr",
          32'({mem_en, mem_we, mem_addr, mem_wdata}),
          32'({2'b11, 8'(i), 3'b000}));
      step();
    end
    chk("clr_done", 32'(eng_busy), 0);
    for (int a = 0; a < 200; a++) golden[a] = '0;
    gm_txn(1'b0, 8'd137, '0);
    chk("clr_cell", 32'(ram[137]), 0);

    // game write then read
    gm_txn(1'b1, 8'd25, 3'd5);
    gm_txn(1'b0, 8'd25, '0);

    // display starves a held game read
    disp_addr = 8'd25; disp_req = 1'b1;
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'd25;
    gm_q.push_back(golden[25]);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("gm_held", 32'(gm_ack), 0);
      chk("dv_held", 32'(disp_valid), 1);
    end
    disp_req = 1'b0;
    step();
    chk("gm_ack_rel", 32'(gm_ack), 1);
    chk("gm_rdata_rel", 32'(gm_rdata),
        32'(gm_q.pop_front()));
    gm_req = 1'b0;
    step();
    chk("gm_ack_pulse", 32'(gm_ack), 0);

    // out-of-range row ignored, row 0 clears the top
    cmd_collapse = 1'b1; cmd_row = 5'd20;
    step();
    cmd_collapse = 1'b0;
    chk("row20_ign", 32'(eng_busy), 0);
    cmd_collapse = 1'b1; cmd_row = 5'd0;
    step();
    cmd_collapse = 1'b0;
    chk("top_busy", 32'(eng_busy), 1);
    wait_idle(n);
    chk("top_len", n, 10);

    // collapse row 19, no display traffic
    fill_bottom();
    cmd_collapse = 1'b1; cmd_row = 5'd19;
    step();
    cmd_collapse = 1'b0;
    chk("col_busy", 32'(eng_busy), 1);
    wait_idle(n);
    collapse_model(19);
    chk("g19", 32'(golden[193]), 2);
    chk("g18", 32'(golden[184]), 1);
    chk("g17", 32'(golden[170]), 0);
    verify_all();

    // same collapse with display every other cycle
    fill_bottom();
    disp_addr = 8'd50;
    cmd_collapse = 1'b1; cmd_row = 5'd19;
    step();
    cmd_collapse = 1'b0;
    n = 0;
    while (eng_busy && n < 3000) begin
      disp_req = ~disp_req;
      step();
      n++;
    end
    disp_req = 1'b0;
    chk("col_disp_done", 32'(eng_busy), 0);
    step();
    collapse_model(19);
    verify_all();

    // reset mid-collapse
    cmd_collapse = 1'b1; cmd_row = 5'd19;
    step();
    cmd_collapse = 1'b0;
    repeat (20) step();
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'd3;
    step();
    chk("rst_pend_ack", 32'(gm_ack), 0);
    RST = 1'b1;
    #1;
    chk("rst_mem_en", 32'(mem_en), 0);
    step();
    chk("rst_mid_busy", 32'(eng_busy), 0);
    chk("rst_mid_ack", 32'(gm_ack), 0);
    RST = 1'b0; gm_req = 1'b0;
    step();
    chk("rst_post_ack", 32'(gm_ack), 0);
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    chk("rst_clr_busy", 32'(eng_busy), 1);
    wait_idle(n);
    chk("rst_clr_len", n, 200);
    for (int a = 0; a < 200; a++) golden[a] = '0;
    gm_txn(1'b0, 8'd0, '0);
    gm_txn(1'b0, 8'd199, '0);
    gm_txn(1'b0, 8'd187, '0);

    step();
    chk("disp_q_left", disp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/playfield_arb.md
PLAYFIELD_ARB -- requirements
Module: playfield_arb

Interface
REQ-001 Parameter COLS, default 10, playfield width in cells.
REQ-002 Parameter ROWS, default 20, playfield height in cells.
REQ-003 Parameter CW, default 3, cell colour code width; 0 = empty.
REQ-004 Port CLK25M  in  1  single clock, 25 MHz pixel clock; all logic on its rising edge.
REQ-005 Port RST  in  1  reset, synchronous, active-high.
REQ-006 Port disp_req  in  1  display read request, one cell per cycle, never stalled.
REQ-007 Port disp_addr  in  8  display cell address (row*COLS+col).
REQ-008 Port disp_valid  out  1  disp_data valid; one cycle after the matching disp_req.
REQ-009 Port disp_data  out  CW  display read data.
REQ-010 Port gm_req, gm_we  in  1 each  game-logic request; gm_we=1 means write.
REQ-011 Port gm_addr  in  8 / gm_wdata in CW  game-logic address and write data.
REQ-012 Port gm_ack  out  1  one-cycle pulse completing a game request; gm_rdata valid with it.
REQ-013 Port gm_rdata  out  CW  game read data.
REQ-014 Port cmd_clear, cmd_collapse  in  1 each  engine command strobes; cmd_row in 5, row to remove.
REQ-015 Port eng_busy  out  1  engine active; commands ignored while high.
REQ-016 Port mem_en, mem_we  out  1 each / mem_addr out 8 / mem_wdata out CW / mem_rdata in CW  single-port RAM with 1-cycle read latency.

Function
REQ-017 Per cycle at most one RAM access; fixed priority: display > engine > game port.
REQ-018 Display granted in the same cycle as disp_req; mem_rdata returned on disp_data with disp_valid the next cycle.
REQ-019 A game request is held (gm_req, gm_we, gm_addr, gm_wdata stable) until gm_ack; granted only when disp_req=0 and eng_busy=0.
REQ-020 gm_ack pulses exactly one cycle after the game grant, for reads and writes alike; a new request may be granted in the ack cycle.
REQ-021 A 1-deep tag register records the owner of each read so that read data is routed to exactly one requester.
REQ-022 Engine FSM states: IDLE, CLR, COL_RD, COL_WR, COL_TOP.
REQ-023 IDLE: cmd_clear -> CLR with cell ptr=0; cmd_collapse with cmd_row<ROWS -> COL_RD at (cmd_row,0), or -> COL_TOP when cmd_row=0; cmd_collapse with cmd_row>=ROWS ignored; simultaneous strobes: clear wins.
REQ-024 CLR writes 0 to cells 0..ROWS*COLS-1 in ascending order, one per granted cycle, then -> IDLE.
REQ-025 COL_RD reads cell (r-1,c), COL_WR writes that data to (r,c); c runs 0..COLS-1, then r decrements; after r=1 completes -> COL_TOP.
REQ-026 COL_TOP writes 0 to row 0 cells 0..COLS-1, then -> IDLE.
REQ-027 An engine step stalls in place (no pointer advance) on any cycle where disp_req=1; a COL_WR following a stalled cycle uses the data captured by the last granted COL_RD.
REQ-028 Address arithmetic is row*8+row*2+col for COLS=10, generic multiply otherwise; 8-bit result; no wrap beyond ROWS*COLS-1 is ever issued.
REQ-029 eng_busy=1 in every state other than IDLE, asserted the cycle after the accepted command.

Reset
REQ-030 On RST: FSM=IDLE; tag cleared; eng_busy, gm_ack, disp_valid, mem_en, mem_we = 0; disp_data, gm_rdata, mem_addr, mem_wdata = 0.
REQ-031 RST mid-operation aborts the engine and any pending game request without ack; RAM contents are not altered by reset.

Structure
REQ-032 COLS, ROWS, CW and the engine state enumeration reside in the shared package tetris_pkg.
REQ-033 Single module; no sub-modules; the RAM is external.

Verification
REQ-034 Game write addr 25 data 5, then read addr 25, disp_req=0 -> each gm_ack one cycle after its request, gm_rdata=5.
REQ-035 disp_req held high for 8 cycles with gm_req high -> gm_ack withheld for all 8; ack 1 cycle after disp_req falls; disp_valid every cycle.
REQ-036 cmd_clear -> 200 consecutive zero writes to addr 0..199, eng_busy high 200 cycles; a following game read of any cell returns 0.
REQ-037 Rows 17,18,19 filled with 1,2,3; cmd_collapse row 19 -> row19=2, row18=1, row17=0, row0=0.
REQ-038 cmd_collapse row 19 with disp_req toggling every other cycle -> result identical to REQ-037; no read/write collision on mem_en.
REQ-039 RST asserted mid-collapse -> eng_busy=0 next cycle, gm_ack=0, new cmd_clear accepted after RST releases.
